// File: rtl/seven_seg_display_arbiter_if.sv
// seven_seg_display_arbiter_if: requester bundle in, shared display bundle out.
// master = requester/display side, slave = arbiter.
interface seven_seg_display_arbiter_if #(
    parameter int NUM_REQ = 3
);
    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ*39-1:0] req_number;
    logic [NUM_REQ-1:0]    req_mode;
    logic [NUM_REQ*8-1:0]  req_points;
    logic [NUM_REQ-1:0]    grant;
    logic [38:0]           disp_number;
    logic                  disp_mode;
    logic [7:0]            disp_points;
    logic                  disp_blank;
    logic [2:0]            owner_idx;

    modport master (
        output req, req_number, req_mode, req_points,
        input  grant, disp_number, disp_mode, disp_points,
        input  disp_blank, owner_idx
    );

    modport slave (
        input  req, req_number, req_mode, req_points,
        output grant, disp_number, disp_mode, disp_points,
        output disp_blank, owner_idx
    );
endinterface

// File: rtl/seven_seg_display_arbiter.sv
// seven_seg_display_arbiter: round-robin display owner with minimum dwell.
// Define SEVEN_SEG_ARB_PREEMPT_EN to let requester 0 preempt any other owner.
module seven_seg_display_arbiter #(
    parameter int NUM_REQ  = 3,
    parameter int TICK_DIV = 100000,
    parameter int DWELL_MS = 1000
) (
    input logic clock,
    input logic reset,
    seven_seg_display_arbiter_if.slave bus
);
    localparam int PW = $clog2(TICK_DIV + 1);
    localparam int DW = $clog2(DWELL_MS + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_MS - 1);
    localparam logic [2:0]    OWNER_RST  = 3'(NUM_REQ - 1);
`ifdef SEVEN_SEG_ARB_PREEMPT_EN
    localparam bit PREEMPT = 1'b1;
`else
    localparam bit PREEMPT = 1'b0;
`endif

    typedef enum logic {IDLE, SHOW} state_e;

    state_e             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [2:0]         owner_q, owner_d;
    logic               blank_q, blank_d;
    logic [38:0]        num_q, num_d;
    logic               mode_q, mode_d;
    logic [7:0]         pts_q, pts_d;
    logic [PW-1:0]      presc_q, presc_d;
    logic [DW-1:0]      dwell_q, dwell_d;

    logic        win_vld, own_req, tick, expire;
    logic        sw_en, ld_en;
    logic [2:0]  win_idx, sw_idx, ld_idx;
    logic [38:0] sel_num;
    logic        sel_mode;
    logic [7:0]  sel_pts;

    assign tick   = (presc_q == PRESC_LAST);
    assign expire = tick && (dwell_q == DWELL_LAST);

    // Two passes: above the owner first, then wrap; owner itself comes last.
    always_comb begin
        win_vld = 1'b0;
        win_idx = owner_q;
        own_req = 1'b0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!win_vld && j > int'(owner_q) && bus.req[j]) begin
                win_vld = 1'b1;
                win_idx = 3'(j);
            end
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!win_vld && j <= int'(owner_q) && bus.req[j]) begin
                win_vld = 1'b1;
                win_idx = 3'(j);
            end
            if (3'(j) == owner_q) own_req = bus.req[j];
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
        blank_d = blank_q;
        presc_d = presc_q;
        dwell_d = dwell_q;
        ld_en   = 1'b0;
        ld_idx  = owner_q;
        sw_en   = 1'b0;
        sw_idx  = win_idx;
        unique case (state_q)
            IDLE: sw_en = win_vld;
            SHOW: begin
                presc_d = tick ? '0 : presc_q + 1'b1;
                dwell_d = tick ? dwell_q + 1'b1 : dwell_q;
                ld_en   = own_req;
                if (expire) begin
                    sw_en = win_vld;
                    if (!win_vld) begin
                        state_d = IDLE;
                        grant_d = '0;
                        blank_d = 1'b1;
                        ld_en   = 1'b0;
                        presc_d = '0;
                        dwell_d = '0;
                    end
                end else if (PREEMPT && owner_q != 3'd0 && bus.req[0]) begin
                    sw_en  = 1'b1;
                    sw_idx = 3'd0;
                end
            end
            default: ;
        endcase
        if (sw_en) begin
            state_d = SHOW;
            grant_d = NUM_REQ'(1) << sw_idx;
            owner_d = sw_idx;
            blank_d = 1'b0;
            ld_en   = 1'b1;
            ld_idx  = sw_idx;
            presc_d = '0;
            dwell_d = '0;
        end
    end

    always_comb begin
        sel_num  = num_q;
        sel_mode = mode_q;
        sel_pts  = pts_q;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (3'(j) == ld_idx) begin
                sel_num  = bus.req_number[39*j +: 39];
                sel_mode = bus.req_mode[j];
                sel_pts  = bus.req_points[8*j +: 8];
            end
        end
        num_d  = ld_en ? sel_num  : num_q;
        mode_d = ld_en ? sel_mode : mode_q;
        pts_d  = ld_en ? sel_pts  : pts_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            owner_q <= OWNER_RST;
            blank_q <= 1'b1;
            num_q   <= '0;
            mode_q  <= 1'b0;
            pts_q   <= '0;
            presc_q <= '0;
            dwell_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            blank_q <= blank_d;
            num_q   <= num_d;
            mode_q  <= mode_d;
            pts_q   <= pts_d;
            presc_q <= presc_d;
            dwell_q <= dwell_d;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.owner_idx   = owner_q;
    assign bus.disp_blank  = blank_q;
    assign bus.disp_number = num_q;
    assign bus.disp_mode   = mode_q;
    assign bus.disp_points = pts_q;
endmodule

// File: doc/seven_seg_display_arbiter.md
Name: seven_seg_display_arbiter

Overview:
Shares the 8-digit seven-segment display path between NUM_REQ requesters, e.g. calculator result, operand entry and error/status sources. Each requester presents number, mode and decimal points with a level request. The arbiter grants one owner at a time, round-robin, with a guaranteed minimum dwell. It drives a single number/mode/points/blank bundle into the display multiplexer.

Parameters:
NUM_REQ, 3, number of requesters (2..8)
TICK_DIV, 100000, clock cycles per 1 ms dwell tick (100 MHz clock)
DWELL_MS, 1000, minimum ms an owner holds the display once granted (>=1)

Ports:
clock  in  1  system clock, all logic on posedge
reset  in  1  asynchronous, active-high
req  in  NUM_REQ  level request per requester
req_number  in  NUM_REQ*39  flattened; requester i at [39*i+38:39*i]
req_mode  in  NUM_REQ  per requester: 0 = decimal, 1 = hex
req_points  in  NUM_REQ*8  flattened; requester i at [8*i+7:8*i]
grant  out  NUM_REQ  one-hot owner, or all zero
disp_number  out  39  to display driver
disp_mode  out  1  to display driver
disp_points  out  8  to display driver
disp_blank  out  1  1 = display path blanked (no owner)
owner_idx  out  3  index of current or last owner

Behaviour:
- Reset (asynchronous, immediate):
  - grant=0, disp_number=0, disp_mode=0, disp_points=0, disp_blank=1, owner_idx=NUM_REQ-1.
  - State=IDLE; prescaler and dwell counter cleared.
  - Reset mid-SHOW abandons the owner with no completion.
- States:
  - IDLE: no owner.
  - SHOW: owner granted, dwell running.
- Arbitration (combinational on sampled req):
  - Search starts at owner_idx+1 mod NUM_REQ and wraps; the first asserted req wins.
  - The current owner is therefore considered last.
  - Out of reset, req[0] has highest precedence.
- IDLE with any req high at edge N:
  - At N+1: state=SHOW, grant one-hot to the winner, owner_idx=winner, disp_blank=0.
  - disp_* are loaded with the winner's slice.
  - Prescaler and dwell counter restart at 0.
- SHOW, owner req high: disp_number/mode/points register the owner's inputs every cycle (1-cycle latency).
- SHOW, owner req low: disp_* frozen at last captured value; grant stays asserted. The minimum dwell is never shortened by a drop.
- Prescaler: counts 0..TICK_DIV-1 and emits a tick on the wrap. The dwell counter increments per tick. Expiry occurs when it reaches DWELL_MS, i.e. exactly DWELL_MS*TICK_DIV cycles after the grant edge.
- On the expiry edge, arbitrate:
  - Another requester pending: switch grant in that same edge, load its data, restart dwell. There is no gap cycle and no blank between owners.
  - Only the current owner pending: keep the owner and restart dwell.
  - None pending: go to IDLE, grant=0, disp_blank=1, disp_* hold their last values.
- Requests asserted mid-dwell wait for expiry and are never lost while held high. A req pulse that drops before it is sampled at an arbitration edge is ignored.
- grant is always one-hot or zero, never changes except at an arbitration edge, and requires no acknowledge.

Optional Feature:
SEVEN_SEG_ARB_PREEMPT_EN
- Defined: requester 0 (error source) preempts.
  - If in SHOW with owner!=0 and req[0] is sampled high, the next edge grants requester 0 and restarts dwell, regardless of the dwell count.
  - While requester 0 owns, the round-robin rule applies at expiry.
- Undefined: requester 0 is an ordinary round-robin participant.

Test Plan:
All tests use NUM_REQ=3, TICK_DIV=4, DWELL_MS=3 (dwell = 12 cycles).
1. Reset asserted for 3 cycles, req=3'b111 -> during reset grant=0, disp_blank=1, disp_number=0. Reset asserted mid-SHOW -> outputs return to reset values immediately, without waiting for a clock edge.
2. From IDLE, req=3'b010, req_number slice1=39'h12345, then changed to 39'h00777 at cycle 5 -> grant=3'b010 and disp_number=39'h12345 one cycle after sampling. disp_number becomes 39'h00777 at cycle 6. Owner is re-granted at cycle 12, with disp_blank=0 throughout.
3. From reset, req=3'b101 held -> grant=001 for 12 cycles, then 100 for 12 cycles, then 001. No blank cycle at any switch.
4. Owner 1 drops req at cycle 3 with disp_number=39'h0ABCD, no other requests -> disp_number stays 39'h0ABCD and grant stays 010 until cycle 12. Next edge: IDLE, grant=0, disp_blank=1.
5. Owner 2 granted, req[0] rises at cycle 5 -> with SEVEN_SEG_ARB_PREEMPT_EN, grant=3'b001 at cycle 6. Without the macro, the switch occurs at cycle 12.
6. Owner 1, req[2] and req[0] both pending at expiry -> grant goes to requester 2 (search starts at owner_idx+1), then requester 0 at the next expiry.
